uc_multiciclo: RTL and testbench

Multicycle control unit for the 8-register accumulator-style CPU, replacing the single-cycle decoder in the multicycle datapath. It sequences each instruction through FETCH/DECODE/EXEC states, waits on a ready handshake from instruction memory, and latches the opcode into an internal instruction register. It also adds a conditional jump on not-zero, call/return with a tracked hardware return-stack depth, and halt/error states.

---
 rtl/uc_multiciclo_if.sv | 39 +++
 rtl/uc_multiciclo.sv | 160 ++++++++++++++++
 tb/tb_uc_multiciclo.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uc_multiciclo_if.sv
`default_nettype none
// ============================================================================
// Module   : uc_multiciclo_if
// Brief    : Control-unit <-> datapath/imem signal bundle.
// Revision : 1.0
// ============================================================================
interface uc_multiciclo_if #(
  parameter int OPW     = 6,
  parameter int ALU_OPW = 3
);
  logic               imem_ready;
  logic [OPW-1:0]     opcode;
  logic               z;
  logic [ALU_OPW-1:0] op;
  logic               ir_we;
  logic               pc_we;
  logic               s_inc;
  logic               s_ret;
  logic               s_inm;
  logic               we3;
  logic               flag_we;
  logic               push;
  logic               pop;
  logic               halted;
  logic               stack_err;

  modport master (
    input  imem_ready, opcode, z,
    output op, ir_we, pc_we, s_inc, s_ret, s_inm, we3, flag_we,
           push, pop, halted, stack_err
  );

  modport slave (
    output imem_ready, opcode, z,
    input  op, ir_we, pc_we, s_inc, s_ret, s_inm, we3, flag_we,
           push, pop, halted, stack_err
  );
endinterface
`default_nettype wire

// File: rtl/uc_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : uc_multiciclo
// Brief    : Multicycle FETCH/DECODE/EXEC control unit with return-stack depth.
// Revision : 1.0
// ============================================================================
module uc_multiciclo #(
  parameter int OPW         = 6,
  parameter int ALU_OPW     = 3,
  parameter int STACK_DEPTH = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  uc_multiciclo_if.master   bus
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] c_DEPTH_MAX = DW'(STACK_DEPTH);

  localparam logic [3:0] c_LOADI = 4'b1000;
  localparam logic [3:0] c_JMP   = 4'b1001;
  localparam logic [3:0] c_JZ    = 4'b1010;
  localparam logic [3:0] c_JNZ   = 4'b1011;
  localparam logic [3:0] c_CALL  = 4'b1100;
  localparam logic [3:0] c_RET   = 4'b1101;
  localparam logic [3:0] c_NOP   = 4'b1110;
  localparam logic [3:0] c_HALT  = 4'b1111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALT   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [OPW-1:0]  r_ir;
  logic [DW-1:0]   r_depth;
  logic [3:0]      w_cls;

  assign w_cls  = r_ir[3:0];
  assign bus.op = r_ir[ALU_OPW-1:0];

  // Upper opcode bits are carried in ir but never decoded.
  generate
    if (OPW > 4) begin : g_ir_hi
      logic w_unused_ir_hi;
      assign w_unused_ir_hi = ^r_ir[OPW-1:4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
      r_depth <= '0;
    end else begin
      r_state <= w_state_next;
      if (bus.ir_we) begin
        r_ir <= bus.opcode;
      end
      // Bounds were already checked in DECODE, so these never wrap.
      if (bus.push) begin
        r_depth <= r_depth + DW'(1);
      end else if (bus.pop) begin
        r_depth <= r_depth - DW'(1);
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    bus.ir_we     = 1'b0;
    bus.pc_we     = 1'b0;
    bus.s_inc     = 1'b1;
    bus.s_ret     = 1'b0;
    bus.s_inm     = 1'b0;
    bus.we3       = 1'b0;
    bus.flag_we   = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.halted    = 1'b0;
    bus.stack_err = 1'b0;

    case (r_state)
      ST_FETCH: begin
        bus.ir_we = bus.imem_ready;
        if (bus.imem_ready) begin
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_cls == c_HALT) begin
          w_state_next = ST_HALT;
        end else if ((w_cls == c_CALL) && (r_depth == c_DEPTH_MAX)) begin
          w_state_next = ST_ERROR;
        end else if ((w_cls == c_RET) && (r_depth == '0)) begin
          w_state_next = ST_ERROR;
        end else begin
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_next = ST_FETCH;
        if (!w_cls[3]) begin
          bus.we3     = 1'b1;
          bus.flag_we = 1'b1;
          bus.pc_we   = 1'b1;
        end else begin
          case (w_cls)
            c_LOADI: begin
              bus.we3   = 1'b1;
              bus.s_inm = 1'b1;
              bus.pc_we = 1'b1;
            end
            c_JMP: begin
              bus.pc_we = 1'b1;
              bus.s_inc = 1'b0;
            end
            c_JZ: begin
              bus.pc_we = 1'b1;
              bus.s_inc = ~bus.z;
            end
            c_JNZ: begin
              bus.pc_we = 1'b1;
              bus.s_inc = bus.z;
            end
            c_CALL: begin
              bus.push  = 1'b1;
              bus.pc_we = 1'b1;
              bus.s_inc = 1'b0;
            end
            c_RET: begin
              bus.pop   = 1'b1;
              bus.pc_we = 1'b1;
              bus.s_ret = 1'b1;
            end
            c_NOP: begin
              bus.pc_we = 1'b1;
            end
            default: begin
            end
          endcase
        end
      end
      ST_HALT: begin
        bus.halted = 1'b1;
      end
      ST_ERROR: begin
        bus.halted    = 1'b1;
        bus.stack_err = 1'b1;
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_uc_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uc_multiciclo
// Brief    : Directed vector bench for uc_multiciclo (STACK_DEPTH = 2).
// Revision : 1.0
// ============================================================================
module tb_uc_multiciclo;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  uc_multiciclo_if #(.OPW(6), .ALU_OPW(3)) bus ();

  uc_multiciclo #(.OPW(6), .ALU_OPW(3), .STACK_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed output order: op, ir_we, pc_we, s_inc, s_ret, s_inm, we3, flag_we,
  // push, pop, halted, stack_err
  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic [5:0]  opc;
    logic        z;
    logic        chk;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl [24];

  function automatic logic [13:0] mk(input logic [2:0] op, input logic iw, input logic pw,
                                     input logic si, input logic sr, input logic sm,
                                     input logic we, input logic fw, input logic pu,
                                     input logic po, input logic h, input logic e);
    return {op, iw, pw, si, sr, sm, we, fw, pu, po, h, e};
  endfunction

  function automatic logic [13:0] fetch_e(input logic [2:0] op, input logic rdy);
    return mk(op, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [13:0] dec_e(input logic [2:0] op);
    return mk(op, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [13:0] halt_e(input logic [2:0] op);
    return mk(op, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic logic [13:0] err_e(input logic [2:0] op);
    return mk(op, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endfunction

  function automatic logic [13:0] call_e();
    return mk(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t v(input logic r, input logic rdy, input logic [5:0] opc,
                             input logic zz, input logic chk, input logic [13:0] e);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.opc = opc; t.z = zz; t.chk = chk; t.exp = e;
    return t;
  endfunction

  function automatic logic [13:0] act();
    return {bus.op, bus.ir_we, bus.pc_we, bus.s_inc, bus.s_ret, bus.s_inm, bus.we3,
            bus.flag_we, bus.push, bus.pop, bus.halted, bus.stack_err};
  endfunction

  // One clock cycle: drive after the falling edge, check before the rising edge.
  task automatic cyc(input logic r, input logic rdy, input logic [5:0] opc, input logic zz,
                     input logic chk, input logic [13:0] e, input string nm);
    @(negedge clk);
    reset          = r;
    bus.imem_ready = rdy;
    bus.opcode     = opc;
    bus.z          = zz;
    #2;
    if (chk) begin
      n_checks++;
      if (act() === e) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got %b expected %b", nm, act(), e);
      end
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 14'b0, "reset");
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    reset          = 1'b1;
    bus.imem_ready = 1'b0;
    bus.opcode     = '0;
    bus.z          = 1'b0;

    tbl[0]  = v(1, 0, 6'b000000, 0, 0, 14'b0);
    // ALU 000101, zero wait
    tbl[1]  = v(0, 1, 6'b000101, 0, 1, fetch_e(3'b000, 1'b1));
    tbl[2]  = v(0, 0, 6'b111111, 0, 1, dec_e(3'b101));
    tbl[3]  = v(0, 0, 6'b111111, 0, 1, mk(3'b101, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    // LOADI with two wait cycles
    tbl[4]  = v(0, 0, 6'b001000, 0, 1, fetch_e(3'b101, 1'b0));
    tbl[5]  = v(0, 0, 6'b001000, 0, 1, fetch_e(3'b101, 1'b0));
    tbl[6]  = v(0, 1, 6'b001000, 0, 1, fetch_e(3'b101, 1'b1));
    tbl[7]  = v(0, 0, 6'b000000, 0, 1, dec_e(3'b000));
    tbl[8]  = v(0, 0, 6'b000000, 0, 1, mk(3'b000, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    // JZ z=1 then z=0
    tbl[9]  = v(0, 1, 6'b101010, 1, 1, fetch_e(3'b000, 1'b1));
    tbl[10] = v(0, 0, 6'b000000, 1, 1, dec_e(3'b010));
    tbl[11] = v(0, 0, 6'b000000, 1, 1, mk(3'b010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl[12] = v(0, 1, 6'b101010, 0, 1, fetch_e(3'b010, 1'b1));
    tbl[13] = v(0, 0, 6'b000000, 0, 1, dec_e(3'b010));
    tbl[14] = v(0, 0, 6'b000000, 0, 1, mk(3'b010, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // JNZ z=1 then z=0
    tbl[15] = v(0, 1, 6'b001011, 1, 1, fetch_e(3'b010, 1'b1));
    tbl[16] = v(0, 0, 6'b000000, 1, 1, dec_e(3'b011));
    tbl[17] = v(0, 0, 6'b000000, 1, 1, mk(3'b011, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl[18] = v(0, 1, 6'b001011, 0, 1, fetch_e(3'b011, 1'b1));
    tbl[19] = v(0, 0, 6'b000000, 0, 1, dec_e(3'b011));
    tbl[20] = v(0, 0, 6'b000000, 0, 1, mk(3'b011, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // NOP
    tbl[21] = v(0, 1, 6'b001110, 0, 1, fetch_e(3'b011, 1'b1));
    tbl[22] = v(0, 0, 6'b000000, 0, 1, dec_e(3'b110));
    tbl[23] = v(0, 0, 6'b000000, 0, 1, mk(3'b110, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].rst, tbl[i].rdy, tbl[i].opc, tbl[i].z, tbl[i].chk, tbl[i].exp,
          $sformatf("vec%0d", i));
    end

    // RET at depth 0 traps to ERROR without popping
    cyc(0, 1, 6'b001101, 0, 1, fetch_e(3'b110, 1'b1), "ret0_fetch");
    cyc(0, 0, 6'b000000, 0, 1, dec_e(3'b101), "ret0_dec");
    for (int i = 0; i < 3; i++) cyc(0, 1, 6'b001110, 0, 1, err_e(3'b101), "ret0_err");
    do_reset();
    cyc(0, 0, 6'b000000, 0, 1, fetch_e(3'b000, 1'b0), "ret0_rst");

    // CALL then RET, then a second RET proves depth is back to 0
    cyc(0, 1, 6'b001100, 0, 1, fetch_e(3'b000, 1'b1), "cr_fetch1");
    cyc(0, 0, 6'b000000, 0, 1, dec_e(3'b100), "cr_dec1");
    cyc(0, 0, 6'b000000, 0, 1, call_e(), "cr_call");
    cyc(0, 1, 6'b001101, 0, 1, fetch_e(3'b100, 1'b1), "cr_fetch2");
    cyc(0, 0, 6'b000000, 0, 1, dec_e(3'b101), "cr_dec2");
    cyc(0, 0, 6'b000000, 0, 1, mk(3'b101, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0), "cr_ret");
    cyc(0, 1, 6'b001101, 0, 1, fetch_e(3'b101, 1'b1), "cr_fetch3");
    cyc(0, 0, 6'b000000, 0, 1, dec_e(3'b101), "cr_dec3");
    cyc(0, 0, 6'b000000, 0, 1, err_e(3'b101), "cr_depth0");
    do_reset();

    // Two CALLs fill the 2-entry stack; the third traps in DECODE
    cyc(0, 1, 6'b001100, 0, 1, fetch_e(3'b000, 1'b1), "ov_fetch1");
    cyc(0, 0, 6'b000000, 0, 1, dec_e(3'b100), "ov_dec1");
    cyc(0, 0, 6'b000000, 0, 1, call_e(), "ov_call1");
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 6'b001100, 0, 1, fetch_e(3'b100, 1'b1), "ov_fetch");
      cyc(0, 0, 6'b000000, 0, 1, dec_e(3'b100), "ov_dec");
      if (k == 0) cyc(0, 0, 6'b000000, 0, 1, call_e(), "ov_call2");
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, 6'b001100, 0, 1, err_e(3'b100), "ov_err");
    do_reset();
    cyc(0, 0, 6'b000000, 0, 1, fetch_e(3'b000, 1'b0), "ov_rst");

    // HALT holds for 10 cycles with memory ready
    cyc(0, 1, 6'b001111, 0, 1, fetch_e(3'b000, 1'b1), "halt_fetch");
    cyc(0, 1, 6'b001100, 0, 1, dec_e(3'b111), "halt_dec");
    for (int i = 0; i < 10; i++) cyc(0, 1, 6'b001100, 1, 1, halt_e(3'b111), "halt_hold");
    do_reset();

    // Reset asserted during a CALL's EXEC cancels the push
    cyc(0, 1, 6'b001100, 0, 1, fetch_e(3'b000, 1'b1), "rx_fetch");
    cyc(0, 0, 6'b000000, 0, 1, dec_e(3'b100), "rx_dec");
    cyc(1, 0, 6'b000000, 0, 1, call_e(), "rx_exec");
    cyc(0, 0, 6'b000000, 0, 1, fetch_e(3'b000, 1'b0), "rx_rst");
    cyc(0, 1, 6'b001101, 0, 1, fetch_e(3'b000, 1'b1), "rx_fetch2");
    cyc(0, 0, 6'b000000, 0, 1, dec_e(3'b101), "rx_dec2");
    cyc(0, 0, 6'b000000, 0, 1, err_e(3'b101), "rx_depth0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
